// File: rtl/layer_step_sequencer_pkg.sv
// layer_seq_pkg: FSM states, step constants and step classification shared by the layer sequencer
package layer_seq_pkg;
  localparam int STEP_PIX1 = 1;
  localparam int STEP_PIX2 = 2;
  localparam int FUSION_STEP = 35;
  localparam int LAST_STEP = 52;
  typedef enum logic [2:0] {IDLE, SETTLE, READ, COMPUTE, ADV, DONE} state_t;
  typedef enum logic [1:0] {PIX, WGT, CMP} kind_t;
  // Odd steps below the last one load weights, except the fusion step which computes
  function automatic kind_t step_kind(input int s, input int fusion, input int last);
    return (s == STEP_PIX1 || s == STEP_PIX2) ? PIX :
           (s[0] && s >= 3 && s < last && s != fusion) ? WGT : CMP;
  endfunction
endpackage

// File: rtl/layer_step_sequencer_if.sv
// layer_step_sequencer_if: RAM read request bus between the sequencer and the pixel/weight RAMs
interface layer_step_sequencer_if #(parameter int ADDR_W = 15);
  logic [ADDR_W-1:0] rd_addr;
  logic rd_en_p;
  logic rd_en_w;
  logic rd_ready;
  logic rd_last;
  modport master(output rd_addr, rd_en_p, rd_en_w, rd_last, input rd_ready);
  modport slave(input rd_addr, rd_en_p, rd_en_w, rd_last, output rd_ready);
endinterface

// File: rtl/layer_step_sequencer_range_walker.sv
// range_walker: walks one latched [first, last) address range under the read-ready handshake
module range_walker #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              active,
  input  logic              ready,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              empty
);
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] stop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= '0;
      stop <= '0;
    end else if (load) begin
      cur <= first;
      stop <= last_in;
    end else if (active && ready) cur <= cur + 1'b1;
  assign empty = first >= last_in;
  assign addr = active ? cur : '0;
  assign last = active && cur == stop - 1'b1;
endmodule

// File: rtl/layer_step_sequencer.sv
// layer_step_sequencer: steps CNN layers, issuing RAM range reads or conv engine runs per step
module layer_step_sequencer #(
  parameter int ADDR_W = 15,
  parameter int STEP_W = 7,
  parameter int LAST_STEP = layer_seq_pkg::LAST_STEP,
  parameter int FUSION_STEP = layer_seq_pkg::FUSION_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [STEP_W-1:0]     step,
  input  logic [ADDR_W-1:0]     map_first,
  input  logic [ADDR_W-1:0]     map_last,
  layer_step_sequencer_if.master rd,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic                  busy,
  output logic                  done
);
  import layer_seq_pkg::*;
  state_t state, nxt;
  kind_t kind;
  logic empty;
  assign kind = step_kind(int'(step), FUSION_STEP, LAST_STEP);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rd.rd_en_p = state == READ && kind == PIX;
  assign rd.rd_en_w = state == READ && kind == WGT;
  range_walker #(.ADDR_W(ADDR_W)) u_walker (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == SETTLE),
    .active(rd.rd_en_p | rd.rd_en_w),
    .ready(rd.rd_ready),
    .first(map_first),
    .last_in(map_last),
    .addr(rd.rd_addr),
    .last(rd.rd_last),
    .empty(empty)
  );
  // eng_done in the eng_start cycle belongs to a previous run, so it is ignored
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? SETTLE : IDLE;
      SETTLE:  nxt = kind == CMP ? COMPUTE : empty ? ADV : READ;
      READ:    nxt = rd.rd_ready && rd.rd_last ? ADV : READ;
      COMPUTE: nxt = eng_done && !eng_start ? ADV : COMPUTE;
      ADV:     nxt = int'(step) == LAST_STEP ? DONE : SETTLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      eng_start <= 1'b0;
    end else begin
      state <= nxt;
      eng_start <= !abort && state == SETTLE && kind == CMP;
      step <= (abort || state == DONE) ? '0 :
              (state == IDLE && start) ? STEP_W'(1) :
              (state == ADV && nxt == SETTLE) ? step + 1'b1 : step;
    end
endmodule

// File: tb/tb_layer_step_sequencer.sv
// tb_layer_step_sequencer: scoreboard bench driving full runs, stalls, empty ranges, abort and reset
module tb_layer_step_sequencer;
  localparam int ADDR_W = 15;
  localparam int STEP_W = 7;
  typedef struct packed {
    logic w;
    logic [ADDR_W-1:0] a;
    logic l;
  } xf_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic eng_done = 1'b0;
  logic [ADDR_W-1:0] map_first, map_last;
  logic [STEP_W-1:0] step;
  logic eng_start, busy, done;

  layer_step_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  layer_step_sequencer #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .LAST_STEP(52), .FUSION_STEP(35)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .step(step),
    .map_first(map_first),
    .map_last(map_last),
    .rd(bus.master),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_pix(input int s);
    return s == 1 || s == 2;
  endfunction
  function automatic bit is_wgt(input int s);
    return s % 2 == 1 && s >= 3 && s <= 51 && s != 35;
  endfunction

  // Address-map model: compute steps return a non-empty range that must be ignored
  int mf[128];
  int ml[128];
  bit empty7 = 1'b0;
  assign map_first = (empty7 && step == 7) ? ADDR_W'(12) : ADDR_W'(mf[step]);
  assign map_last = (empty7 && step == 7) ? ADDR_W'(12) : ADDR_W'(ml[step]);

  xf_t exp_q[$];
  int cmp_q[$];

  task automatic plan();
    xf_t x;
    int f, l;
    for (int s = 1; s <= 52; s++) begin
      f = (empty7 && s == 7) ? 12 : mf[s];
      l = (empty7 && s == 7) ? 12 : ml[s];
      if (is_pix(s) || is_wgt(s)) begin
        for (int a = f; a < l; a++) begin
          x = {is_wgt(s), ADDR_W'(a), a == l - 1};
          exp_q.push_back(x);
        end
      end else cmp_q.push_back(s);
    end
  endtask

  int rdy_mode = 0;
  int eng_lat = 1;
  bit force_done = 1'b0;
  int cyc = 0;
  logic [3:0] pat = 4'b1001;

  initial begin
    int ecnt;
    ecnt = 0;
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rd_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[cyc[1:0]] : 1'($urandom_range(0, 1));
      if (ecnt > 0) begin
        ecnt--;
        eng_done = ecnt == 0 || force_done;
      end else eng_done = force_done;
      if (eng_start) ecnt = eng_lat;
    end
  end

  int pix_cnt = 0, wgt_cnt = 0, eng_cnt = 0, done_cnt = 0, t7 = 0;
  logic [STEP_W-1:0] prev_step = '0;
  bit waiting = 1'b0;
  bit stalled = 1'b0;
  logic [ADDR_W+2:0] snap = '0;

  always @(negedge clk) begin
    xf_t cur_x;
    logic [ADDR_W+2:0] now;
    logic en;
    cyc++;
    en = bus.rd_en_p | bus.rd_en_w;
    cur_x = {bus.rd_en_w, bus.rd_addr, bus.rd_last};
    now = {bus.rd_en_p, bus.rd_en_w, bus.rd_addr, bus.rd_last};
    if (en) check("en_excl", 32'(bus.rd_en_p & bus.rd_en_w), 0);
    if (stalled) check("stall_hold", 32'(now), 32'(snap));
    if (en && bus.rd_ready) begin
      if (bus.rd_en_p) pix_cnt++;
      else wgt_cnt++;
      if (exp_q.size() == 0) check("xfer_extra", 32'(now), 0);
      else check("xfer", 32'(cur_x), 32'(exp_q.pop_front()));
    end
    if (eng_start) begin
      eng_cnt++;
      waiting = 1'b1;
      if (cmp_q.size() == 0) check("eng_extra", 32'(step), 0);
      else check("eng_step", 32'(step), cmp_q.pop_front());
    end else if (eng_done) waiting = 1'b0;
    if (!busy) waiting = 1'b0;
    if (done) done_cnt++;
    if (step != prev_step && step != 0) begin
      check("step_seq", 32'(step), 32'(prev_step) + 1);
      check("adv_wait", 32'(waiting), 0);
      if (step == 7) t7 = cyc;
      if (step == 8 && empty7) check("empty_adv", cyc - t7, 2);
    end
    prev_step = step;
    snap = now;
    stalled = en && !bus.rd_ready && rst_n && !abort;
  end

  task automatic run(input bit chk_lat);
    int n;
    plan();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (chk_lat) begin
      check("lat_step1", 32'(step), 1);
      check("lat_settle_en", 32'(bus.rd_en_p), 0);
      @(posedge clk);
      #1;
      check("lat_first_rd", {16'(bus.rd_en_p), 16'(bus.rd_addr)}, 32'h0001_0000);
    end
    n = 0;
    while (!done && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("run_done", 32'(done), 1);
    @(posedge clk);
    #1;
    check("end_idle", {30'(step), busy, done}, 0);
    check("xfer_left", exp_q.size(), 0);
    check("eng_left", cmp_q.size(), 0);
  endtask

  initial begin
    int wb, k, n, p0, w0, e0, d0;
    int wsz[4];
    wsz = '{27, 36, 45, 57};
    wb = 0;
    k = 0;
    for (int s = 0; s < 128; s++) begin
      mf[s] = 0;
      ml[s] = 5;
    end
    mf[1] = 0;
    ml[1] = 1600;
    mf[2] = 1600;
    ml[2] = 3200;
    for (int s = 3; s <= 51; s++)
      if (is_wgt(s)) begin
        mf[s] = wb;
        ml[s] = wb + wsz[k % 4];
        wb = ml[s];
        k++;
      end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outs", {busy, done, eng_start, bus.rd_en_p, bus.rd_en_w, bus.rd_last, 26'(bus.rd_addr)}, 0);
    check("reset_step", 32'(step), 0);

    p0 = pix_cnt; w0 = wgt_cnt; e0 = eng_cnt; d0 = done_cnt;
    run(1'b1);
    check("full_pix", pix_cnt - p0, 3200);
    check("full_wgt", wgt_cnt - w0, 990);
    check("full_eng", eng_cnt - e0, 26);
    check("full_done", done_cnt - d0, 1);

    rdy_mode = 1;
    eng_lat = 5;
    p0 = pix_cnt; w0 = wgt_cnt; e0 = eng_cnt; d0 = done_cnt;
    run(1'b0);
    check("stall_pix", pix_cnt - p0, 3200);
    check("stall_wgt", wgt_cnt - w0, 990);
    check("stall_eng", eng_cnt - e0, 26);
    check("stall_done", done_cnt - d0, 1);

    rdy_mode = 0;
    eng_lat = 1;
    empty7 = 1'b1;
    repeat (8) @(posedge clk);
    w0 = wgt_cnt; d0 = done_cnt;
    run(1'b0);
    check("empty_wgt", wgt_cnt - w0, 945);
    check("empty_done", done_cnt - d0, 1);
    empty7 = 1'b0;

    d0 = done_cnt;
    plan();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(step == 5 && bus.rd_addr == ADDR_W'(mf[5] + 10)) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_reach", 32'(bus.rd_en_w), 1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    check("abort_outs", {busy, done, eng_start, bus.rd_en_p, bus.rd_en_w, bus.rd_last, 26'(bus.rd_addr)}, 0);
    check("abort_step", 32'(step), 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stay_idle", 32'(busy), 0);
    exp_q.delete();
    cmp_q.delete();
    rdy_mode = 2;
    run(1'b1);
    rdy_mode = 0;

    eng_lat = 20;
    plan();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(step == 20 && eng_start) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_reach", 32'(eng_start), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    start = 1'b1;
    force_done = 1'b1;
    #1;
    check("rst_outs", {busy, done, eng_start, bus.rd_en_p, bus.rd_en_w, bus.rd_last, 26'(bus.rd_addr)}, 0);
    check("rst_step", 32'(step), 0);
    @(posedge clk);
    #1;
    check("rst_hold", {30'(step), busy, eng_start}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    force_done = 1'b0;
    exp_q.delete();
    cmp_q.delete();
    repeat (25) @(posedge clk);
    #1;
    check("rst_idle", {31'(step), busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_step_sequencer.md
Name: layer_step_sequencer

Overview:
- Top-level scheduler for the MobileNet fusion CNN.
- Steps the 7-bit layer `step` from 1 to LAST_STEP and drives the combinational address-map block with it.
- On load steps, walks the returned [first, last) range, issuing pixel or weight RAM reads under a ready handshake.
- On compute steps, starts the convolution engine and waits for its done.

Parameters:
- ADDR_W, 15, RAM address width; matches map firstaddr/lastaddr.
- STEP_W, 7, step counter width.
- LAST_STEP, 52, final step index (PW4 decoder compute).
- FUSION_STEP, 35, fusion compute step (odd, but not a load step).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; ignored while busy
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- step  out  STEP_W  current step, to address map
- map_first  in  ADDR_W  start address from map (combinational from step)
- map_last  in  ADDR_W  end address, exclusive
- rd_addr  out  ADDR_W  RAM read address
- rd_en_p  out  1  pixel RAM read request
- rd_en_w  out  1  weight RAM read request
- rd_ready  in  1  RAM/consumer accepts the current request
- rd_last  out  1  current request is the final one of the step
- eng_start  out  1  one-cycle conv engine start pulse
- eng_done  in  1  conv engine finished current step
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after LAST_STEP completes

Behaviour:
- Reset: state=IDLE; step=0; rd_addr=0; rd_en_p=0; rd_en_w=0; rd_last=0; eng_start=0; busy=0; done=0.
- Step classification is decoded internally from `step`; the map's re_RAM flags are not used.
  - Pixel load: step 1, 2.
  - Weight load: odd steps 3..33 and 37..51.
  - Compute: every other step in 1..LAST_STEP, including FUSION_STEP.
- IDLE: on start, step<=1, go to SETTLE.
- SETTLE: exactly 1 cycle; lets the map output settle.
  - At end of cycle, latch cur<=map_first and end<=map_last.
  - Load step with map_first>=map_last (empty range): go to ADV, no reads.
  - Load step otherwise: go to READ.
  - Compute step: go to COMPUTE, eng_start=1 in the first COMPUTE cycle only.
- READ:
  - rd_en_p (pixel step) or rd_en_w (weight step) held high; never both.
  - rd_addr=cur; rd_last=(cur==end-1).
  - Transfer = rd_en & rd_ready; on transfer, cur<=cur+1.
  - rd_addr, rd_en and rd_last stay stable while rd_ready=0.
  - Transfer with rd_last=1: next state ADV; rd_en drops the next cycle.
- COMPUTE: eng_done is ignored in the eng_start cycle; the first eng_done=1 afterwards goes to ADV.
- ADV: 1 cycle.
  - step==LAST_STEP: go to DONE.
  - Otherwise step<=step+1, go to SETTLE.
- DONE: done=1 for 1 cycle, then IDLE with step<=0.
- Latency: start at cycle 0 → step=1 at cycle 1 → first rd_en_p at cycle 2. Zero-stall step overhead = 2 cycles (SETTLE + ADV).
- Arithmetic: cur/end are unsigned ADDR_W; no wrap because end<=2^ADDR_W-1 by construction; step is unsigned STEP_W.
- Simultaneous events:
  - abort has priority over everything, including start, an eng_done, or a last transfer in the same cycle.
  - abort clears all outputs to their reset values next cycle; done is not pulsed.
  - start during busy: no effect.
- Reset mid-operation: immediate return to reset values; the engine/RAM must tolerate dropped requests.

Decomposition:
- Package layer_seq_pkg:
  - State enum: IDLE, SETTLE, READ, COMPUTE, ADV, DONE.
  - Constants: STEP_PIX1=1, STEP_PIX2=2, FUSION_STEP=35, LAST_STEP=52.
  - Function step_kind(step) returning PIX/WGT/CMP.
- One sub-module, range_walker: holds cur/end, the handshake and rd_last. Load/advance control comes from the FSM.

Test Plan:
- Full run, map params picture_size=40, 3by3=9, 1by1=1, rd_ready=1, eng_done one cycle after eng_start → 3200 rd_en_p transfers (addresses 0..3199), 990 rd_en_w transfers (0..989, contiguous), 26 eng_start pulses, one done pulse, then step=0.
- Step 1 with rd_ready toggled 1-0-0-1 → rd_addr holds 1 during stalls; no duplicated or skipped address; rd_last only on address 1599.
- Step 35 → no rd_en_w asserted; one eng_start; step 36 only after eng_done.
- Map forced map_first=map_last=12 on step 7 → zero reads; step goes 7→8 within 2 cycles.
- Abort asserted during step 5 mid-READ (rd_addr=10) → next cycle IDLE, all outputs 0, no done; a following start restarts at step 1, address 0.
- rst_n low for 1 cycle during COMPUTE of step 20 → outputs at reset values immediately; start and eng_done ignored while rst_n=0.
